// File: rtl/vel_sample_ctrl.sv
// Periodic velocity sampler for a modular position counter.
// Every eff_len cycles the position change is captured. It is wrap-corrected
// in stage 1 and scaled into a speed magnitude in stage 2. The result is then
// presented on a valid/ready output with a sticky overrun flag.
module vel_sample_ctrl #(
  parameter int COUNTS_PER_REV = 1498,
  parameter int WIN_W          = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [15:0]      count,
  input  logic             clr_ovr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [15:0]      o_delta,
  output logic [15:0]      o_speed,
  output logic             o_dir,
  output logic             o_overrun,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic signed [16:0] HALF_REV = 17'(COUNTS_PER_REV / 2);
  localparam logic signed [16:0] FULL_REV = 17'(COUNTS_PER_REV);

  state_t                  state, state_nxt;
  logic                    do_prime, do_capture;
  logic [WIN_W-1:0]        timer, eff_len;
  logic [15:0]             prev;
  logic signed [16:0]      raw, raw_wrapped;
  logic                    s1_valid;
  logic [15:0]             s1_delta;
  logic [15:0]             mag, speed_calc;

  // A zero window length would never expire, so it is treated as one cycle.
  assign eff_len = (win_len == '0) ? WIN_W'(1) : win_len;
  assign o_busy  = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the prime/capture strobes.
  always_comb begin
    // NOTE: defaults assigned before the case keep every path driven, so no latches.
    state_nxt  = state;
    do_prime   = 1'b0;
    do_capture = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = PRIME;
      PRIME: begin
        if (!enable) state_nxt = IDLE;
        else begin
          do_prime  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable)          state_nxt  = IDLE;
        else if (timer == WIN_W'(1)) do_capture = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window timer and reference position. A reload re-samples win_len, so a
  // change in win_len only takes effect at a window boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      prev  <= '0;
    end else if (do_prime || do_capture) begin
      timer <= eff_len;
      prev  <= count;
    end else if (state == RUN && enable) begin
      timer <= timer - WIN_W'(1);
    end
  end

  // Raw difference and the correction back into +/- half a revolution.
  always_comb begin
    raw = $signed({1'b0, count}) - $signed({1'b0, prev});
    if (raw > HALF_REV)        raw_wrapped = raw - FULL_REV;
    else if (raw < -HALF_REV)  raw_wrapped = raw + FULL_REV;
    else                       raw_wrapped = raw;
  end

  // Stage 1: wrap-corrected delta.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_delta <= '0;
    end else begin
      s1_valid <= do_capture;
      if (do_capture) s1_delta <= raw_wrapped[15:0];
    end
  end

  // The speed scale is m * 3.625, built from shifts. The magnitude never
  // exceeds half a revolution, so the 16-bit sum cannot overflow.
  always_comb begin
    mag        = s1_delta[15] ? (16'd0 - s1_delta) : s1_delta;
    speed_calc = mag + (mag >> 1) + (mag << 1) + (mag >> 3);
  end

  // Stage 2: output register with the valid/ready handshake and the overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_delta   <= '0;
      o_speed   <= '0;
      o_dir     <= 1'b1;
      o_overrun <= 1'b0;
    end else begin
      if (s1_valid) begin
        o_valid <= 1'b1;
        o_delta <= s1_delta;
        o_speed <= speed_calc;
        o_dir   <= ~s1_delta[15];
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // When a clear and a new overrun coincide, the set takes priority.
      if (s1_valid && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (clr_ovr)                    o_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/vel_sample_ctrl.md
VEL_SAMPLE_CTRL -- requirements
Module: vel_sample_ctrl

Interface
REQ-001 SHALL have parameter COUNTS_PER_REV, default 1498: position modulus; input count ranges 0..COUNTS_PER_REV-1.
REQ-002 SHALL have parameter WIN_W, default 20: width of win_len.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: run periodic velocity sampling while high.
REQ-006 SHALL have port win_len, input, WIN_W bits: sample window length in clk cycles.
REQ-007 SHALL have port count, input, 16 bits: decoder position.
REQ-008 SHALL have port clr_ovr, input, 1 bit: clears o_overrun.
REQ-009 SHALL have port i_ready, input, 1 bit: consumer ready.
REQ-010 SHALL have port o_valid, output, 1 bit: result available.
REQ-011 SHALL have port o_delta, output, 16 bits: signed two's-complement counts per window.
REQ-012 SHALL have port o_speed, output, 16 bits: unsigned scaled magnitude.
REQ-013 SHALL have port o_dir, output, 1 bit: 1 when o_delta >= 0.
REQ-014 SHALL have port o_overrun, output, 1 bit: sticky flag; a result was overwritten before it was consumed.
REQ-015 SHALL have port o_busy, output, 1 bit: high when state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-017 SHALL move IDLE->PRIME on the cycle after enable is sampled high.
REQ-018 SHALL, in PRIME, latch prev<=count and timer<=eff_len, then go to RUN; eff_len = win_len, or 1 if win_len==0.
REQ-019 SHALL, in RUN, decrement timer each cycle.
REQ-020 SHALL, in the RUN cycle with timer==1 (capture cycle), register raw = count - prev (17-bit signed), set prev<=count and reload timer<=eff_len (win_len re-sampled); capture cycles are therefore exactly eff_len cycles apart, with no gap between windows.
REQ-021 SHALL wrap-correct in pipeline stage 1, registered: if raw > COUNTS_PER_REV/2 (749), subtract COUNTS_PER_REV; if raw < -(COUNTS_PER_REV/2), add COUNTS_PER_REV.
REQ-022 SHALL form in stage 2, registered into the outputs, with m = |delta|:
  o_delta = delta; o_dir = (delta >= 0); o_speed = m + (m>>1) + (m<<1) + (m>>3), truncating, 16-bit, no overflow because m <= 749.
REQ-023 SHALL assert o_valid in capture cycle + 2.
REQ-024 SHALL hold o_delta, o_speed and o_dir stable while o_valid && !i_ready.
REQ-025 SHALL treat a cycle with o_valid && i_ready as a transfer; o_valid then falls next cycle unless a new result loads that same cycle.
REQ-026 SHALL, when a new result loads while o_valid && !i_ready, overwrite the data, keep o_valid high and set o_overrun.
REQ-027 SHALL clear o_overrun only on clr_ovr or rst; if clr_ovr and a new overrun coincide, set wins.
REQ-028 SHALL, on enable low in PRIME or RUN, go to IDLE next cycle and discard the partial window.
REQ-029 SHALL still complete a result already in stage 1/2 when enable drops, and hold it under the normal handshake.
REQ-030 SHALL NOT change timer or window length when win_len changes mid-window; the new value takes effect at the next reload.

Reset
REQ-031 SHALL, on rst high at any clock edge, force state IDLE and set timer, prev, pipeline registers, o_valid, o_delta, o_speed, o_overrun and o_busy to 0, and o_dir to 1.
REQ-032 SHALL give rst priority over enable, clr_ovr and i_ready.
REQ-033 SHALL NOT emit a result from a window interrupted by rst.

Verification
REQ-034 SHALL cover steady position: win_len=10, count held 500, i_ready=1 -> o_valid pulses every 10 cycles; o_delta=0, o_speed=0, o_dir=1.
REQ-035 SHALL cover forward motion: win_len=100, count +1 per cycle from 0 -> o_delta=+100, o_speed=362, o_dir=1.
REQ-036 SHALL cover wrap in both directions: prev=1490, cur=10 -> o_delta=+18, o_speed=65; prev=5, cur=1490 -> o_delta=-13 (0xFFF3), o_speed=46, o_dir=0.
REQ-037 SHALL cover back-pressure: i_ready=0 across two captures -> o_overrun=1 and o_delta equals the second window's value; then clr_ovr pulse -> o_overrun=0 next cycle.
REQ-038 SHALL cover reset mid-window: rst pulse at timer==5 -> next cycle all outputs at reset values and state IDLE; with enable still high, PRIME follows and the first o_valid arrives eff_len+2 cycles after PRIME.
REQ-039 SHALL cover zero window: win_len=0 -> capture every cycle and o_valid continuously high with i_ready=1.
